// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, drives instruction-memory address and fills the
// IF/ID register, honouring redirect/stall from downstream and stopping on halt.
module fetch_stage #(
  parameter int unsigned             PC_WIDTH    = 16,
  parameter int unsigned             INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
  parameter logic [3:0]              HALT_OPCODE = 4'hF,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    PC_next,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic [PC_WIDTH-1:0]    if_pc_plus2,
  output logic                   if_valid,
  output logic                   halted,
  output logic [15:0]            fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [PC_WIDTH-1:0]    if_pc_q, if_pc_d;
  logic [PC_WIDTH-1:0]    if_pc_plus2_q, if_pc_plus2_d;
  logic                   if_valid_q, if_valid_d;
  logic [15:0]            fetch_count_q, fetch_count_d;

  logic [PC_WIDTH-1:0] pc_plus2;
  logic [PC_WIDTH-1:0] redirect_target;
  logic                is_halt;

  assign pc_plus2        = pc_q + PC_WIDTH'(2);
  assign redirect_target = {redirect_pc[PC_WIDTH-1:1], 1'b0};
  assign is_halt         = (imem_rdata[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

  // NOTE: every signal gets its hold value first so no path leaves it unassigned
  // (an unassigned path in always_comb would infer a latch).
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus2_d = if_pc_plus2_q;
    if_valid_d    = if_valid_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      BOOT: begin
        pc_d       = RESET_PC;
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
        state_d    = RUN;
      end
      RUN: begin
        if (redirect) begin
          // Redirect squashes whatever is on imem_rdata, halt words included.
          pc_d       = redirect_target;
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_instr_d    = imem_rdata;
          if_pc_d       = pc_q;
          if_pc_plus2_d = pc_plus2;
          if_valid_d    = 1'b1;
          fetch_count_d = (fetch_count_q == 16'hFFFF) ? fetch_count_q
                                                      : fetch_count_q + 16'd1;
          if (is_halt) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_plus2;
          end
        end
      end
      HALTED: begin
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_instr_q    <= NOP_INSTR;
      if_pc_q       <= '0;
      if_pc_plus2_q <= '0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus2_q <= if_pc_plus2_d;
      if_valid_q    <= if_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign PC_next     = rst ? RESET_PC : pc_d;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus2 = if_pc_plus2_q;
  assign if_valid    = if_valid_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// redirect/stall/reset traffic checked against a behavioural fetch model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr, imem_rdata, PC_next;
  logic [15:0] if_instr, if_pc, if_pc_plus2, fetch_count;
  logic        if_valid, halted;

  int checks   = 0;
  int failures = 0;

  // Instruction memory: word at A is 16'h1000 + A, optionally one halt word.
  logic        halt_en   = 1'b0;
  logic [15:0] halt_addr = 16'h0000;
  always_comb begin
    imem_rdata = (halt_en && imem_addr == halt_addr) ? 16'hF000 : 16'h1000 + imem_addr;
  end

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .PC_next(PC_next), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus2(if_pc_plus2), .if_valid(if_valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: the machine is booting, halted, or fetching.
  logic        m_boot, m_halted, m_valid;
  logic [15:0] m_pc, m_instr, m_ifpc, m_ifpc2, m_count;
  logic [15:0] pcn_dut;  // PC_next observed just before the edge

  // Drive one cycle of inputs, sample PC_next before the edge, advance model.
  task automatic step(input logic r, input logic s, input logic rd, input logic [15:0] rp);
    logic [15:0] word;
    rst = r; stall = s; redirect = rd; redirect_pc = rp;
    #3;
    pcn_dut = PC_next;
    word    = imem_rdata;
    if (r) begin
      m_boot = 1; m_halted = 0; m_pc = 16'h0000; m_instr = 16'h0000;
      m_ifpc = 0; m_ifpc2 = 0; m_valid = 0; m_count = 0;
    end else if (m_boot) begin
      m_boot = 0; m_pc = 16'h0000; m_instr = 16'h0000; m_valid = 0;
    end else if (m_halted) begin
      m_instr = 16'h0000; m_valid = 0;
    end else if (rd) begin
      m_pc = rp & 16'hFFFE; m_instr = 16'h0000; m_valid = 0;
    end else if (!s) begin
      m_instr = word; m_ifpc = m_pc; m_ifpc2 = m_pc + 16'd2; m_valid = 1;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      if (word[15:12] == 4'hF) m_halted = 1;
      else m_pc = m_pc + 16'd2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic boot_to_run();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 1, 1, 16'h1234);  // arbitrary pre-reset activity
    rst = 1; #1;
    checks++; if (PC_next !== 16'h0000) begin failures++; $display("FAIL reset_pc_next got=%h exp=0000", PC_next); end
    step(1, 1, 1, 16'h0100);
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", imem_addr); end
    checks++; if (if_instr !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=0000", if_instr); end
    checks++; if (if_pc !== 16'h0000 || if_pc_plus2 !== 16'h0000) begin failures++; $display("FAIL reset_ifpc got=%h/%h exp=0000/0000", if_pc, if_pc_plus2); end
    checks++; if (if_valid !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL reset_flags got valid=%b halted=%b exp=0/0", if_valid, halted); end
    checks++; if (fetch_count !== 16'h0000) begin failures++; $display("FAIL reset_count got=%h exp=0000", fetch_count); end
    // Boot cycle ignores stall.
    step(0, 1, 0, 0);
    checks++; if (if_valid !== 1'b0 || imem_addr !== 16'h0000) begin failures++; $display("FAIL boot_cycle got valid=%b pc=%h exp=0/0000", if_valid, imem_addr); end
  endtask

  task automatic test_free_run();
    boot_to_run();
    for (int k = 1; k <= 30; k++) begin
      step(0, 0, 0, 0);
      checks++; if (pcn_dut !== 16'(2 * k)) begin failures++; $display("FAIL run_pc_next k=%0d got=%h exp=%h", k, pcn_dut, 16'(2 * k)); end
      if (k == 25) begin
        checks++; if (pcn_dut !== 16'd50) begin failures++; $display("FAIL run_pc_next_25 got=%0d exp=50", pcn_dut); end
      end
      checks++; if (if_valid !== 1'b1 || if_pc !== 16'(2 * (k - 1)) || if_instr !== 16'(16'h1000 + 2 * (k - 1)))
        begin failures++; $display("FAIL run_ifid k=%0d got v=%b pc=%h i=%h", k, if_valid, if_pc, if_instr); end
      checks++; if (if_pc_plus2 !== 16'(2 * k) || fetch_count !== 16'(k))
        begin failures++; $display("FAIL run_count k=%0d got p2=%h cnt=%0d exp=%h/%0d", k, if_pc_plus2, fetch_count, 16'(2 * k), k); end
    end
  endtask

  task automatic test_redirect();
    for (int s = 0; s < 2; s++) begin
      boot_to_run();
      for (int n = 0; n < 8; n++) step(0, 0, 0, 0);
      checks++; if (imem_addr !== 16'h0010) begin failures++; $display("FAIL redir_setup got=%h exp=0010", imem_addr); end
      step(0, s[0], 1, 16'h0040);
      checks++; if (if_valid !== 1'b0 || imem_addr !== 16'h0040) begin failures++; $display("FAIL redir_bubble stall=%0d got v=%b pc=%h exp=0/0040", s, if_valid, imem_addr); end
      step(0, 0, 0, 0);
      checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0040 || if_instr !== 16'h1040)
        begin failures++; $display("FAIL redir_target stall=%0d got v=%b pc=%h i=%h exp=1/0040/1040", s, if_valid, if_pc, if_instr); end
    end
  endtask

  task automatic test_stall();
    boot_to_run();
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      step(0, 1, 0, 0);
      checks++; if (imem_addr !== 16'h0008 || if_pc !== 16'h0006 || if_instr !== 16'h1006 || fetch_count !== 16'd4 || if_valid !== 1'b1)
        begin failures++; $display("FAIL stall_hold n=%0d got pc=%h ifpc=%h i=%h cnt=%0d", n, imem_addr, if_pc, if_instr, fetch_count); end
    end
    step(0, 0, 0, 0);
    checks++; if (if_pc !== 16'h0008 || if_instr !== 16'h1008 || fetch_count !== 16'd5)
      begin failures++; $display("FAIL stall_resume got ifpc=%h i=%h cnt=%0d exp=0008/1008/5", if_pc, if_instr, fetch_count); end
  endtask

  task automatic test_halt();
    halt_en = 1; halt_addr = 16'h000C;
    boot_to_run();
    for (int n = 0; n < 6; n++) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++; if (if_instr !== 16'hF000 || if_valid !== 1'b1 || halted !== 1'b1 || imem_addr !== 16'h000C || fetch_count !== 16'd7)
      begin failures++; $display("FAIL halt_latch got i=%h v=%b h=%b pc=%h cnt=%0d", if_instr, if_valid, halted, imem_addr, fetch_count); end
    for (int n = 0; n < 4; n++) begin
      step(0, n[0], n[1], 16'h0080);
      checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0000 || halted !== 1'b1 || imem_addr !== 16'h000C || fetch_count !== 16'd7 || pcn_dut !== 16'h000C)
        begin failures++; $display("FAIL halt_hold n=%0d got v=%b i=%h h=%b pc=%h pcn=%h cnt=%0d", n, if_valid, if_instr, halted, imem_addr, pcn_dut, fetch_count); end
    end
    step(1, 0, 0, 0);
    checks++; if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 16'h0000 || fetch_count !== 16'd0 || if_pc !== 16'h0000)
      begin failures++; $display("FAIL halt_reset got h=%b v=%b pc=%h cnt=%0d ifpc=%h", halted, if_valid, imem_addr, fetch_count, if_pc); end
    halt_en = 0;
  endtask

  task automatic test_halt_redirect();
    halt_en = 1; halt_addr = 16'h0004;
    boot_to_run();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 16'h0020);  // halt word is on imem_rdata this cycle
    checks++; if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 16'h0020)
      begin failures++; $display("FAIL halt_redir got h=%b v=%b pc=%h exp=0/0/0020", halted, if_valid, imem_addr); end
    step(0, 0, 0, 0);
    checks++; if (halted !== 1'b0 || if_valid !== 1'b1 || if_pc !== 16'h0020 || if_instr !== 16'h1020)
      begin failures++; $display("FAIL halt_redir_fetch got h=%b v=%b ifpc=%h i=%h", halted, if_valid, if_pc, if_instr); end
    halt_en = 0;
  endtask

  task automatic test_wrap();
    boot_to_run();
    step(0, 0, 1, 16'hFFFE);
    step(0, 0, 0, 0);
    checks++; if (if_pc !== 16'hFFFE || if_instr !== 16'h0FFE || if_pc_plus2 !== 16'h0000 || imem_addr !== 16'h0000)
      begin failures++; $display("FAIL wrap_top got ifpc=%h i=%h p2=%h pc=%h", if_pc, if_instr, if_pc_plus2, imem_addr); end
    step(0, 0, 0, 0);
    checks++; if (if_pc !== 16'h0000 || if_instr !== 16'h1000 || if_valid !== 1'b1)
      begin failures++; $display("FAIL wrap_zero got ifpc=%h i=%h v=%b", if_pc, if_instr, if_valid); end
    step(0, 0, 1, 16'h0021);
    checks++; if (imem_addr !== 16'h0020) begin failures++; $display("FAIL odd_redir got=%h exp=0020", imem_addr); end
    step(0, 0, 0, 0);
    checks++; if (if_pc !== 16'h0020 || if_instr !== 16'h1020) begin failures++; $display("FAIL odd_redir_fetch got ifpc=%h i=%h", if_pc, if_instr); end
  endtask

  task automatic test_random();
    boot_to_run();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        halt_en = 1'($urandom_range(0, 1));
        halt_addr = 16'($urandom_range(0, 63) * 2);
      end
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, 16'($urandom_range(0, 16'h0FFF)));
      checks++;
      if (pcn_dut !== m_pc || imem_addr !== m_pc || if_valid !== m_valid || if_instr !== m_instr ||
          halted !== m_halted || fetch_count !== m_count ||
          (m_valid && (if_pc !== m_ifpc || if_pc_plus2 !== m_ifpc2))) begin
        failures++;
        $display("FAIL random n=%0d got pcn=%h pc=%h v=%b i=%h h=%b cnt=%0d ifpc=%h exp pc=%h v=%b i=%h h=%b cnt=%0d ifpc=%h",
                 n, pcn_dut, imem_addr, if_valid, if_instr, halted, fetch_count, if_pc,
                 m_pc, m_valid, m_instr, m_halted, m_count, m_ifpc);
      end
    end
    halt_en = 0;
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    @(posedge clk); #1;
    test_reset();
    test_free_run();
    test_redirect();
    test_stall();
    test_halt();
    test_halt_redirect();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
